instruction_fetch: RTL

- Fetch stage directly upstream of the register bank.
- Tracks the bank's registered `current_PC` and reads instruction memory through a request/ready handshake.
- Holds the fetched word with its address for decode, prefetching PC+1 speculatively and refetching when the bank's PC diverges (branch, system call, return).
- Also drains aborted requests and flags a memory timeout fault.

---
 rtl/instruction_fetch.sv | 128 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage feeding decode: tracks the bank's current_PC, prefetches PC+1 and refetches on divergence.
// Latency 2 cycles enable-to-valid with zero-wait memory; request held until mem_ready, timeout raises a sticky fault.
module instruction_fetch #(
    parameter int ADDR_WIDTH         = 32,
    parameter int INSTRUCTION_LENGTH = 16,
    parameter int TIMEOUT_WIDTH      = 8
) (
    input  logic                          fast_clock,
    input  logic                          reset,
    input  logic                          fetch_enable,
    input  logic                          flush,
    input  logic                          consume,
    input  logic [ADDR_WIDTH-1:0]         current_PC,
    output logic                          mem_request,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    input  logic                          mem_ready,
    input  logic [INSTRUCTION_LENGTH-1:0] mem_data,
    output logic [INSTRUCTION_LENGTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]         instruction_PC,
    output logic                          instruction_valid,
    output logic                          fetch_fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = '1;

    logic [2:0]               state, state_n;
    logic [ADDR_WIDTH-1:0]    fetch_addr, fetch_addr_n;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt, wait_cnt_n, wait_inc;
    logic                     capture;

    assign mem_address = fetch_addr;

    always_comb begin
        state_n      = state;
        fetch_addr_n = fetch_addr;
        wait_cnt_n   = wait_cnt;
        capture      = 1'b0;
        wait_inc     = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + 1'b1;
        case (state)
            S_IDLE: begin
                if (!flush && fetch_enable) begin
                    fetch_addr_n = current_PC;
                    wait_cnt_n   = '0;
                    state_n      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // The outstanding read must still complete before memory is free.
                    wait_cnt_n = '0;
                    state_n    = S_DRAIN;
                end else if (mem_ready) begin
                    if (fetch_addr == current_PC) begin
                        capture = 1'b1;
                        state_n = S_HOLD;
                    end else begin
                        fetch_addr_n = current_PC;
                        wait_cnt_n   = '0;
                    end
                end else begin
                    wait_cnt_n = wait_inc;
                    if (wait_inc == LIMIT) state_n = S_FAULT;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else if (instruction_PC != current_PC) begin
                    fetch_addr_n = current_PC;
                    wait_cnt_n   = '0;
                    state_n      = S_WAIT;
                end else if (consume) begin
                    if (fetch_enable) begin
                        fetch_addr_n = instruction_PC + 1'b1;
                        wait_cnt_n   = '0;
                        state_n      = S_WAIT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                // A flush here changes nothing: the drain is already discarding.
                if (mem_ready) begin
                    state_n = S_IDLE;
                end else begin
                    wait_cnt_n = wait_inc;
                    if (wait_inc == LIMIT) state_n = S_FAULT;
                end
            end
            S_FAULT: begin
                if (flush) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge fast_clock or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            fetch_addr        <= '0;
            wait_cnt          <= '0;
            instruction       <= '0;
            instruction_PC    <= '0;
            instruction_valid <= 1'b0;
            fetch_fault       <= 1'b0;
            mem_request       <= 1'b0;
        end else begin
            state             <= state_n;
            fetch_addr        <= fetch_addr_n;
            wait_cnt          <= wait_cnt_n;
            instruction_valid <= (state_n == S_HOLD);
            fetch_fault       <= (state_n == S_FAULT);
            mem_request       <= (state_n == S_WAIT) || (state_n == S_DRAIN);
            if (capture) begin
                instruction    <= mem_data;
                instruction_PC <= fetch_addr;
            end
        end
    end

endmodule
